// File: rtl/reg_file_mp_pkg.sv
// Shared constants for the multi-port register file: MIPS register indices and default geometry.
package reg_file_mp_pkg;
  localparam int unsigned REG_ZERO         = 0;
  localparam int unsigned REG_V0           = 2;
  localparam int unsigned REG_A0           = 4;
  localparam int unsigned REG_RA           = 31;
  localparam int unsigned DEFAULT_DATA_W   = 32;
  localparam int unsigned DEFAULT_NUM_REGS = 32;
endpackage

// File: rtl/reg_file_scoreboard.sv
// Per-register pending-write bits; a same-cycle set beats a commit, register 0 is never busy.
module reg_file_scoreboard #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                set_en_i,
  input  logic [ADDR_W-1:0]   set_id_i,
  input  logic [NUM_REGS-1:0] commit_i,
  output logic [NUM_REGS-1:0] busy_o
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  always_comb begin
    busy_d = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      busy_d[i] = (set_en_i && (set_id_i == ADDR_W'(i))) || (busy_q[i] && !commit_i[i]);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-read-port MIPS register file with link port, syscall taps and hazard scoreboard.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data (and busy) onto reads and taps.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int unsigned DATA_W   = DEFAULT_DATA_W,
  parameter int unsigned NUM_REGS = DEFAULT_NUM_REGS,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
  parameter int unsigned N_RD     = 2,
  parameter int unsigned LINK_REG = REG_RA,
  parameter int unsigned TAP0_REG = REG_V0,
  parameter int unsigned TAP1_REG = REG_A0
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [N_RD*ADDR_W-1:0]   rd_id,
  output logic [N_RD*DATA_W-1:0]   rd_value,
  output logic [N_RD-1:0]          rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_id,
  input  logic [DATA_W-1:0]        wr_value,
  input  logic                     link_wr_en,
  input  logic [DATA_W-1:0]        link_wr_value,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_set_id,
  output logic [DATA_W-1:0]        tap0_value,
  output logic [DATA_W-1:0]        tap1_value,
  output logic                     wr_collision
);

  localparam int unsigned N_LOOK = N_RD + 2;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic                collision_q;
  logic                collision_d;
  logic                main_act_c;
  logic [NUM_REGS-1:0] commit_c;
  logic [NUM_REGS-1:0] busy_c;

  logic [ADDR_W-1:0]   look_id  [N_LOOK];
  logic [DATA_W-1:0]   look_val [N_LOOK];
  logic                look_busy[N_LOOK];

  assign main_act_c  = wr_en && (wr_id != ADDR_W'(REG_ZERO));
  assign collision_d = main_act_c && link_wr_en && (wr_id == ADDR_W'(LINK_REG));

  // Write decode: link port wins over main port on the same target.
  always_comb begin
    commit_c = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) regs_d[i] = regs_q[i];
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      if (link_wr_en && (i == LINK_REG)) begin
        regs_d[i]   = link_wr_value;
        commit_c[i] = 1'b1;
      end else if (main_act_c && (wr_id == ADDR_W'(i))) begin
        regs_d[i]   = wr_value;
        commit_c[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      collision_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      collision_q <= collision_d;
    end
  end

  reg_file_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clock    (clock),
    .reset_n  (reset_n),
    .set_en_i (sb_set),
    .set_id_i (sb_set_id),
    .commit_i (commit_c),
    .busy_o   (busy_c)
  );

  // Read ports and the two taps share one lookup path; NUM_REGS is a power of 2 so every id is in range.
  always_comb begin
    for (int unsigned k = 0; k < N_RD; k++) look_id[k] = rd_id[k*ADDR_W +: ADDR_W];
    look_id[N_RD]   = ADDR_W'(TAP0_REG);
    look_id[N_RD+1] = ADDR_W'(TAP1_REG);
    for (int unsigned k = 0; k < N_LOOK; k++) begin
      look_val[k]  = regs_q[look_id[k]];
      look_busy[k] = busy_c[look_id[k]];
`ifdef REG_FILE_BYPASS_EN
      if ((link_wr_en && (look_id[k] == ADDR_W'(LINK_REG))) ||
          (main_act_c && (look_id[k] == wr_id))) begin
        look_val[k]  = (link_wr_en && (look_id[k] == ADDR_W'(LINK_REG))) ? link_wr_value : wr_value;
        look_busy[k] = sb_set && (sb_set_id == look_id[k]);
      end
`endif
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < N_RD; k++) begin
      rd_value[k*DATA_W +: DATA_W] = look_val[k];
      rd_busy[k]                   = look_busy[k];
    end
  end

  assign tap0_value   = look_val[N_RD];
  assign tap1_value   = look_val[N_RD+1];
  assign wr_collision = collision_q;

endmodule
